// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse transmit scheduler and its
// character lookup table.
//   state_t      : scheduler FSM states
//   *_U          : element and gap durations, in dot units
//   lut_entry_t  : lookup result {valid, is_space, len, pat}. pat holds len
//                  elements right-aligned, first element in bit len-1,
//                  1 = dash.
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ELEM_ON,
        ELEM_GAP,
        CHAR_GAP,
        WORD_GAP,
        END
    } state_t;

    localparam int unsigned DOT_U        = 1;
    localparam int unsigned DASH_U       = 3;
    localparam int unsigned ELEM_GAP_U   = 1;
    localparam int unsigned CHAR_GAP_U   = 3;
    // Added on top of the character gap that already closed the previous
    // character, giving the 7-unit inter-word space.
    localparam int unsigned WORD_EXTRA_U = 4;

    typedef struct packed {
        logic       valid;
        logic       is_space;
        logic [2:0] len;
        logic [4:0] pat;
    } lut_entry_t;

    function automatic lut_entry_t sym(input logic [2:0] len, input logic [4:0] pat);
        lut_entry_t e;
        e.valid    = 1'b1;
        e.is_space = 1'b0;
        e.len      = len;
        e.pat      = pat;
        return e;
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Combinational ASCII -> Morse pattern lookup. Covers A-Z, a-z (folded to
// upper case), 0-9 and space. Anything else returns valid=0.
//   i_char  : ASCII byte
//   o_entry : lut_entry_t result
// -----------------------------------------------------------------------------
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0]  i_char,
    output lut_entry_t  o_entry
);

    logic [7:0] up_char;

    always_comb begin
        up_char = to_upper(i_char);
        o_entry = '0;
        case (up_char)
            8'h20: begin
                o_entry.valid    = 1'b1;
                o_entry.is_space = 1'b1;
            end
            "A": o_entry = sym(3'd2, 5'b00001);
            "B": o_entry = sym(3'd4, 5'b01000);
            "C": o_entry = sym(3'd4, 5'b01010);
            "D": o_entry = sym(3'd3, 5'b00100);
            "E": o_entry = sym(3'd1, 5'b00000);
            "F": o_entry = sym(3'd4, 5'b00010);
            "G": o_entry = sym(3'd3, 5'b00110);
            "H": o_entry = sym(3'd4, 5'b00000);
            "I": o_entry = sym(3'd2, 5'b00000);
            "J": o_entry = sym(3'd4, 5'b00111);
            "K": o_entry = sym(3'd3, 5'b00101);
            "L": o_entry = sym(3'd4, 5'b00100);
            "M": o_entry = sym(3'd2, 5'b00011);
            "N": o_entry = sym(3'd2, 5'b00010);
            "O": o_entry = sym(3'd3, 5'b00111);
            "P": o_entry = sym(3'd4, 5'b00110);
            "Q": o_entry = sym(3'd4, 5'b01101);
            "R": o_entry = sym(3'd3, 5'b00010);
            "S": o_entry = sym(3'd3, 5'b00000);
            "T": o_entry = sym(3'd1, 5'b00001);
            "U": o_entry = sym(3'd3, 5'b00001);
            "V": o_entry = sym(3'd4, 5'b00001);
            "W": o_entry = sym(3'd3, 5'b00011);
            "X": o_entry = sym(3'd4, 5'b01001);
            "Y": o_entry = sym(3'd4, 5'b01011);
            "Z": o_entry = sym(3'd4, 5'b01100);
            "0": o_entry = sym(3'd5, 5'b11111);
            "1": o_entry = sym(3'd5, 5'b01111);
            "2": o_entry = sym(3'd5, 5'b00111);
            "3": o_entry = sym(3'd5, 5'b00011);
            "4": o_entry = sym(3'd5, 5'b00001);
            "5": o_entry = sym(3'd5, 5'b00000);
            "6": o_entry = sym(3'd5, 5'b10000);
            "7": o_entry = sym(3'd5, 5'b11000);
            "8": o_entry = sym(3'd5, 5'b11100);
            "9": o_entry = sym(3'd5, 5'b11110);
            default: o_entry = '0;
        endcase
    end

endmodule

// File: rtl/morse_tx_sched.sv
// -----------------------------------------------------------------------------
// morse_tx_sched
// Round-robin, message-atomic scheduler for a shared Morse keying line.
// The grant is held from the first byte until the END that follows the byte
// flagged last; each character is keyed in dot units of UNIT_DIV clocks.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_req_valid   : per-requester byte valid
//   i_req_data    : per-requester ASCII byte, requester n on [8n+7:8n]
//   i_req_last    : byte is the final one of its message
//   o_req_ready   : one-hot, high for the owner while fetching a byte
//   o_grant       : one-hot current message owner, 0 when idle
//   o_morse       : keyed line, 1 = tone on
//   o_busy        : high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module morse_tx_sched
    import morse_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int UNIT_DIV = 1000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NREQ-1:0]     i_req_valid,
    input  logic [8*NREQ-1:0]   i_req_data,
    input  logic [NREQ-1:0]     i_req_last,
    output logic [NREQ-1:0]     o_req_ready,
    output logic [NREQ-1:0]     o_grant,
    output logic                o_morse,
    output logic                o_busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DIV_W = $clog2(UNIT_DIV);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic               last_q, last_d;
    logic [4:0]         pat_q, pat_d;          // remaining elements, next one in bit 4
    logic [2:0]         elem_left_q, elem_left_d;
    logic [DIV_W-1:0]   div_q, div_d;          // clocks within the current unit
    logic [2:0]         unit_q, unit_d;        // whole units spent in the current state

    // ---------------------------------------------------------------- requesters
    logic [7:0]         req_byte [NREQ];
    logic [NREQ-1:0]    ptr_mask;              // requesters at index >= ptr

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign req_byte[gi] = i_req_data[8*gi +: 8];
        assign ptr_mask[gi] = (PTR_W'(gi) >= ptr_q);
    end

    logic [7:0]  cur_data;
    logic        cur_valid;
    logic        cur_last;
    lut_entry_t  lut_entry;

    assign cur_data  = req_byte[owner_q];
    assign cur_valid = i_req_valid[owner_q];
    assign cur_last  = i_req_last[owner_q];

    morse_lut u_lut (
        .i_char  (cur_data),
        .o_entry (lut_entry)
    );

    // ------------------------------------------------------------- arbitration
    // Requesters at or above ptr take precedence; if none are valid, wrap to
    // the lowest valid index overall.
    logic [NREQ-1:0]    masked_valid;
    logic [NREQ-1:0]    pick_vec;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [NREQ-1:0]    win_onehot;

    assign masked_valid = i_req_valid & ptr_mask;
    assign pick_vec     = (|masked_valid) ? masked_valid : i_req_valid;
    assign win_found    = |i_req_valid;

    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        for (int n = NREQ - 1; n >= 0; n--) begin
            if (pick_vec[n]) begin
                win_idx       = PTR_W'(n);
                win_onehot    = '0;
                win_onehot[n] = 1'b1;
            end
        end
    end

    // ----------------------------------------------------------------- timing
    logic [2:0] dur_units;
    logic       unit_tick;
    logic       span_done;

    always_comb begin
        case (state_q)
            ELEM_ON:  dur_units = pat_q[4] ? 3'(DASH_U) : 3'(DOT_U);
            ELEM_GAP: dur_units = 3'(ELEM_GAP_U);
            CHAR_GAP: dur_units = 3'(CHAR_GAP_U);
            WORD_GAP: dur_units = 3'(WORD_EXTRA_U);
            default:  dur_units = 3'd1;
        endcase
    end

    assign unit_tick = (div_q == DIV_W'(UNIT_DIV - 1));
    assign span_done = unit_tick && (unit_q == (dur_units - 3'd1));

    // ------------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        last_d      = last_q;
        pat_d       = pat_q;
        elem_left_d = elem_left_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = FETCH;
                    owner_d = win_idx;
                    grant_d = win_onehot;
                end
            end
            FETCH: begin
                if (cur_valid) begin
                    last_d = cur_last;
                    if (!lut_entry.valid) begin
                        state_d = END;
                    end else if (lut_entry.is_space) begin
                        state_d = WORD_GAP;
                    end else begin
                        state_d     = ELEM_ON;
                        // Left-align so the first element sits in bit 4.
                        pat_d       = lut_entry.pat << (3'd5 - lut_entry.len);
                        elem_left_d = lut_entry.len;
                    end
                end
            end
            ELEM_ON: begin
                if (span_done) begin
                    if (elem_left_q > 3'd1) begin
                        state_d     = ELEM_GAP;
                        elem_left_d = elem_left_q - 3'd1;
                        pat_d       = {pat_q[3:0], 1'b0};
                    end else begin
                        state_d = CHAR_GAP;
                    end
                end
            end
            ELEM_GAP: begin
                if (span_done) begin
                    state_d = ELEM_ON;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (span_done) begin
                    state_d = END;
                end
            end
            END: begin
                if (last_q) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_q == PTR_W'(NREQ - 1)) ? '0 : (owner_q + PTR_W'(1));
                end else begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Unit counters restart on every state change so each span is exact.
    always_comb begin
        if (state_d != state_q) begin
            div_d  = '0;
            unit_d = '0;
        end else if (unit_tick) begin
            div_d  = '0;
            unit_d = unit_q + 3'd1;
        end else begin
            div_d  = div_q + DIV_W'(1);
            unit_d = unit_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            last_q      <= 1'b0;
            pat_q       <= '0;
            elem_left_q <= '0;
            div_q       <= '0;
            unit_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            pat_q       <= pat_d;
            elem_left_q <= elem_left_d;
            div_q       <= div_d;
            unit_q      <= unit_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign o_morse     = (state_q == ELEM_ON);
    assign o_busy      = (state_q != IDLE);
    assign o_grant     = grant_q;
    assign o_req_ready = (state_q == FETCH) ? grant_q : '0;

endmodule

// File: tb/tb_morse_tx_sched.sv
module tb_morse_tx_sched;

    localparam int NR = 2;
    localparam int D  = 4;
    localparam int TW = 2 + 2 * NR;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [8*NR-1:0]    req_data;
    logic [NR-1:0]      req_last;
    logic [NR-1:0]      o_req_ready;
    logic [NR-1:0]      o_grant;
    logic               o_morse;
    logic               o_busy;

    always #5 clk = ~clk;

    morse_tx_sched #(.NREQ(NR), .UNIT_DIV(D)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_morse     (o_morse),
        .o_busy      (o_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference Morse table, A-Z then 0-9.
    string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--..", "-----", ".----", "..---", "...--",
                          "....-", ".....", "-....", "--...", "---..", "----."};

    function automatic string code_of(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (u >= "a" && u <= "z") u = u - 8'd32;
        if (u >= "A" && u <= "Z") return codes[int'(u) - 65];
        if (u >= "0" && u <= "9") return codes[26 + int'(u) - 48];
        return "";
    endfunction

    logic [7:0]      msg [NR][$];
    int              stl [NR][$];
    int              pos [NR];
    int              cnt [NR];
    int              ptr_m;
    logic [TW-1:0]   tr [$];

    task automatic set_msg(input int r, input string s);
        msg[r].delete();
        stl[r].delete();
        for (int i = 0; i < s.len(); i++) begin
            msg[r].push_back(s[i]);
            stl[r].push_back((i == 0) ? 0 : int'($urandom_range(0, 3)));
        end
    endtask

    function automatic void push(input int n, input logic m, input logic b,
                                 input logic [NR-1:0] g, input logic [NR-1:0] rdy);
        for (int i = 0; i < n; i++) tr.push_back({m, b, g, rdy});
    endfunction

    // Expected per-cycle {morse, busy, grant, ready} for a round where every
    // requester in s raises its first byte together while the line is idle.
    task automatic build(input logic [NR-1:0] s);
        logic [NR-1:0] rem;
        logic [NR-1:0] g;
        int            w;
        int            fl;
        string         cd;
        rem = s;
        tr.delete();
        while (rem != '0) begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (ptr_m + k) % NR;
                if (w < 0 && rem[i]) w = i;
            end
            g = '0;
            g[w] = 1'b1;
            for (int j = 0; j < msg[w].size(); j++) begin
                fl = (j == 0) ? 1 : ((stl[w][j] > 1) ? stl[w][j] : 1);
                push(fl, 1'b0, 1'b1, g, g);
                if (msg[w][j] == 8'h20) begin
                    push(4 * D, 1'b0, 1'b1, g, '0);
                end else begin
                    cd = code_of(msg[w][j]);
                    if (cd.len() > 0) begin
                        for (int i = 0; i < cd.len(); i++) begin
                            push((cd[i] == "-") ? 3 * D : D, 1'b1, 1'b1, g, '0);
                            if (i < cd.len() - 1) push(D, 1'b0, 1'b1, g, '0);
                        end
                        push(3 * D, 1'b0, 1'b1, g, '0);
                    end
                end
                push(1, 1'b0, 1'b1, g, '0);
            end
            rem[w] = 1'b0;
            ptr_m  = (w + 1) % NR;
            push(1, 1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic set_byte(input int r);
        req_data[8*r +: 8] = msg[r][pos[r]];
        req_last[r]        = (pos[r] == msg[r].size() - 1);
    endtask

    // Called #1 after a clock edge with the DUT idle.
    task automatic run_round(input string name, input logic [NR-1:0] s);
        logic [NR-1:0] acc;
        build(s);
        acc = '0;
        for (int r = 0; r < NR; r++) begin
            cnt[r] = 0;
            if (s[r]) begin
                pos[r] = 0;
                set_byte(r);
                req_valid[r] = 1'b1;
            end else begin
                pos[r] = msg[r].size();
                req_valid[r] = 1'b0;
            end
        end
        for (int k = 0; k < tr.size(); k++) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (acc[r]) begin
                    pos[r]++;
                    if (pos[r] < msg[r].size()) begin
                        set_byte(r);
                        if (stl[r][pos[r]] == 0) begin
                            req_valid[r] = 1'b1;
                        end else begin
                            req_valid[r] = 1'b0;
                            req_last[r]  = ~req_last[r];  // junk while not valid
                            cnt[r]       = 0;
                        end
                    end else begin
                        req_valid[r] = 1'b0;
                    end
                end
            end
            chk($sformatf("%s_cyc%0d", name, k),
                32'({o_morse, o_busy, o_grant, o_req_ready}), 32'(tr[k]));
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r] && pos[r] < msg[r].size() && o_req_ready[r]) begin
                    if (cnt[r] >= stl[r][pos[r]] - 1) begin
                        set_byte(r);
                        req_valid[r] = 1'b1;
                    end else begin
                        cnt[r]++;
                    end
                end
            end
            acc = req_valid & o_req_ready;
        end
        for (int r = 0; r < NR; r++) begin
            if (s[r]) chk($sformatf("%s_consumed%0d", name, r), 32'(pos[r]), 32'(msg[r].size()));
        end
    endtask

    string pool = "ABCKQZabcmqy0123456789  #!.";

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        ptr_m     = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_morse", 32'(o_morse), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_msg(0, "E");    run_round("t1_E", 2'b01);
        set_msg(0, "a");    run_round("t2_a", 2'b01);
        set_msg(0, "A");    run_round("t2_A", 2'b01);
        set_msg(0, "E E");  run_round("t3_EsE", 2'b01);
        set_msg(0, "#");    run_round("t5_junk", 2'b01);
        set_msg(0, "ET5");  set_msg(1, "K");  run_round("t4_both", 2'b11);
        set_msg(0, "N");    set_msg(1, "2");  run_round("t4_again", 2'b11);
        set_msg(1, "m");    run_round("t4_req1", 2'b10);

        for (int n = 0; n < 20; n++) begin
            for (int r = 0; r < NR; r++) begin
                string s;
                int    len;
                s   = "";
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) begin
                    s = {s, string'(pool[$urandom_range(0, pool.len() - 1)])};
                end
                set_msg(r, s);
            end
            run_round($sformatf("rnd%0d", n), 2'($urandom_range(1, 3)));
        end

        // Reset in the middle of a dash, with the pointer moved off 0 first.
        set_msg(0, "T");
        run_round("t6_pre", 2'b01);
        set_msg(0, "0");
        pos[0] = 0;
        set_byte(0);
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_grant", 32'(o_grant), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("t6_rise", 32'(o_morse), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_middash", 32'(o_morse), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_morse", 32'(o_morse), 32'd0);
        chk("t6_rst_grant", 32'(o_grant), 32'd0);
        chk("t6_rst_ready", 32'(o_req_ready), 32'd0);
        chk("t6_rst_busy",  32'(o_busy), 32'd0);
        rst   = 1'b0;
        ptr_m = 0;
        @(posedge clk);
        #1;
        set_msg(0, "E");  set_msg(1, "I");  run_round("t6_after", 2'b11);
        set_msg(1, "S");  run_round("t6_req1", 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
